dbg_cmd_arbiter: RTL and testbench
==================================

// Module: dbg_cmd_arbiter
// PURPOSE
//  Shares the single core debug command bus (cmd/addr/wdata -> core debug unit, rdata/done <- it)
//  among NUM_REQ debug masters (e.g. JTAG host, UART monitor, trace unit).
//  Round-robin arbitration; one command in flight at a time.
//  Holds cmd level-stable until done, then waits for done to clear before the next command.
//  Aborts a stuck command after TIMEOUT_CYCLES.
// PARAMETERS
//  NUM_REQ         2     number of requesters (>=2); IDXW = $clog2(NUM_REQ)
//  TIMEOUT_CYCLES  1024  max cycles cmd is driven without done before abort (>=2)
// PORTS
//  clk          in   1           clock
//  rstn_i       in   1           reset, asynchronous, active-low
//  req_i        in   NUM_REQ     per-requester command request, level
//  cmd_i        in   8*NUM_REQ   per-requester command, slice k = [8k+7:8k]
//  addr_i       in   32*NUM_REQ  per-requester address (reg index in [4:0])
//  wdata_i      in   32*NUM_REQ  per-requester write data (reg value / new pc)
//  ack_o        out  NUM_REQ     one-hot 1-cycle completion pulse
//  rdata_o      out  32          read data, valid only with ack_o
//  err_o        out  1           timeout flag, valid only with ack_o
//  busy_o       out  1           high whenever state != IDLE
//  dbg_cmd_o    out  8           command to core debug unit, 0 = none
//  dbg_addr_o   out  32          address to core debug unit
//  dbg_wdata_o  out  32          write data to core debug unit
//  dbg_rdata_i  in   32          read data from core debug unit
//  dbg_done_i   in   1           done from core debug unit (registered there; may linger 1+ cycle)
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; RR pointer = NUM_REQ-1 (req0 has first priority); timeout counter 0.
//  All outputs are registered.
//  Requester rules:
//   - hold req_i and its cmd/addr/wdata stable until its ack_o pulse.
//   - deassert req_i (or present a new command) in the cycle after ack_o.
//   - dropping req_i early is ignored: the latched command completes and ack still pulses.
//  FSM IDLE:
//   - if any req_i, select winner: first set bit searching from ptr+1 upward, wrapping mod NUM_REQ.
//   - latch winner's cmd/addr/wdata; ptr <= winner.
//   - if cmd != 0 -> ISSUE; dbg_cmd_o/addr/wdata valid the next cycle (req at t -> dbg_cmd_o at t+1).
//   - if cmd == 0 -> no bus activity; ack_o[winner] pulses next cycle, rdata_o=0, err_o=0; -> WAIT_CLR.
//   - no req: remain IDLE, dbg_* = 0.
//  FSM ISSUE:
//   - dbg_* held constant; counter increments each cycle.
//   - dbg_done_i=1 at cycle u:
//       - at u+1: dbg_cmd_o=0, dbg_addr_o=0, dbg_wdata_o=0;
//       - at u+1: ack_o[winner]=1, rdata_o=dbg_rdata_i sampled at u, err_o=0;
//       - -> WAIT_CLR.
//   - counter reaches TIMEOUT_CYCLES-1 with no done:
//       - dbg_cmd_o is driven exactly TIMEOUT_CYCLES cycles, then cleared to 0;
//       - ack_o[winner]=1, rdata_o=0, err_o=1; -> WAIT_CLR.
//   - done and timeout in the same cycle: done wins, err_o=0.
//  FSM WAIT_CLR:
//   - dbg_cmd_o=0; stay until dbg_done_i=0, then -> IDLE.
//   - prevents a lingering done being credited to the next command.
//  ack_o, rdata_o, err_o: exactly one cycle, then return to 0.
//  Counter cleared on entering ISSUE; width $clog2(TIMEOUT_CYCLES)+1.
//  Requests arriving while busy wait; no request is lost or duplicated.
//  Rotating pointer: every continuously-asserted requester is served within NUM_REQ grants.
//  Reset mid-command:
//   - immediate return to reset values; no ack for the aborted command.
//   - the core debug unit's halt state is not touched by this block.
// TESTING
//  1 req0 cmd=0x05, model done 2 cycles after cmd with rdata=0x0000_1000 -> dbg_cmd_o=0x05 from t+1, ack_o=01, rdata_o=0x1000, err_o=0, dbg_cmd_o=0 with ack.
//  2 req0,req1 both asserted from reset, cmd 0x01/0x02 -> 0x01 issued and acked first, then 0x02; repeat both -> req0 then req1 again (ptr rotation).
//  3 TIMEOUT_CYCLES=16, req1 cmd=0x03, model never done -> dbg_cmd_o=0x03 for 16 cycles, then 0; ack_o=10, err_o=1, rdata_o=0.
//  4 model holds done 3 cycles after cmd drop; req1 pending -> no new dbg_cmd_o until done=0, then req1's cmd issued.
//  5 rstn_i low mid-ISSUE -> all outputs 0 asynchronously; after release req0|req1 -> req0 served first.
//  6 req0 cmd=0x00 -> ack_o=01 at t+1, dbg_cmd_o stays 0 throughout, err_o=0.

Source files
------------

// File: rtl/dbg_cmd_arbiter.sv
// dbg_cmd_arbiter: round-robin sharing of the core debug command bus
// among NUM_REQ debug masters; one command in flight, timeout abort.
module dbg_cmd_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [8*NUM_REQ-1:0]  cmd_i,
  input  logic [32*NUM_REQ-1:0] addr_i,
  input  logic [32*NUM_REQ-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [7:0]            dbg_cmd_o,
  output logic [31:0]           dbg_addr_o,
  output logic [31:0]           dbg_wdata_o,
  input  logic [31:0]           dbg_rdata_i,
  input  logic                  dbg_done_i
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDXW-1:0] PTR_RST  = IDXW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CLR
  } state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     ptr_q, ptr_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ack_d;
  logic [31:0]         rdata_d;
  logic                err_d;
  logic                busy_d;
  logic [7:0]          cmd_d;
  logic [31:0]         addr_d;
  logic [31:0]         wdata_d;

  logic [7:0]          cmd_a   [NUM_REQ];
  logic [31:0]         addr_a  [NUM_REQ];
  logic [31:0]         wdata_a [NUM_REQ];

  logic                win_vld;
  logic [IDXW-1:0]     win_idx;
  logic [NUM_REQ-1:0]  win_oh;
  logic [NUM_REQ-1:0]  cur_oh;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign cmd_a[g]   = cmd_i[8*g +: 8];
    assign addr_a[g]  = addr_i[32*g +: 32];
    assign wdata_a[g] = wdata_i[32*g +: 32];
  end

  // Search starts just after the last winner, so it loses priority next.
  always_comb begin : rr_pick
    int cand;
    cand    = 0;
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_vld && req_i[IDXW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IDXW'(cand);
      end
    end
  end

  assign win_oh = NUM_REQ'(1) << win_idx;
  assign cur_oh = NUM_REQ'(1) << ptr_q;

  always_comb begin : fsm_next
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    rdata_d = '0;
    err_d   = 1'b0;
    cmd_d   = dbg_cmd_o;
    addr_d  = dbg_addr_o;
    wdata_d = dbg_wdata_o;
    unique case (state_q)
      S_IDLE: begin
        cmd_d   = '0;
        addr_d  = '0;
        wdata_d = '0;
        if (win_vld) begin
          ptr_d = win_idx;
          if (cmd_a[win_idx] != 8'h00) begin
            cmd_d   = cmd_a[win_idx];
            addr_d  = addr_a[win_idx];
            wdata_d = wdata_a[win_idx];
            cnt_d   = '0;
            state_d = S_ISSUE;
          end else begin
            ack_d   = win_oh;
            state_d = S_WAIT_CLR;
          end
        end
      end
      S_ISSUE: begin
        // done has priority over a coinciding timeout
        if (dbg_done_i) begin
          cmd_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
          ack_d   = cur_oh;
          rdata_d = dbg_rdata_i;
          state_d = S_WAIT_CLR;
        end else if (cnt_q == CNT_LAST) begin
          cmd_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
          ack_d   = cur_oh;
          err_d   = 1'b1;
          state_d = S_WAIT_CLR;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_WAIT_CLR: begin
        cmd_d   = '0;
        addr_d  = '0;
        wdata_d = '0;
        if (!dbg_done_i) state_d = S_IDLE;
      end
      default: begin
        cmd_d   = '0;
        addr_d  = '0;
        wdata_d = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= PTR_RST;
      cnt_q       <= '0;
      ack_o       <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
      dbg_cmd_o   <= '0;
      dbg_addr_o  <= '0;
      dbg_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ack_o       <= ack_d;
      rdata_o     <= rdata_d;
      err_o       <= err_d;
      busy_o      <= busy_d;
      dbg_cmd_o   <= cmd_d;
      dbg_addr_o  <= addr_d;
      dbg_wdata_o <= wdata_d;
    end
  end

endmodule

// File: tb/tb_dbg_cmd_arbiter.sv
// tb_dbg_cmd_arbiter: directed steps plus randomized traffic checked
// against a transaction-level arbiter and debug-unit model.
module tb_dbg_cmd_arbiter;

  localparam int NREQ = 2;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic [1:0]    req_i;
  logic [15:0]   cmd_i;
  logic [63:0]   addr_i;
  logic [63:0]   wdata_i;
  logic [1:0]    ack_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic          busy_o;
  logic [7:0]    dbg_cmd_o;
  logic [31:0]   dbg_addr_o;
  logic [31:0]   dbg_wdata_o;
  logic [31:0]   dbg_rdata_i;
  logic          dbg_done_i;

  logic          rq [NREQ];
  logic [7:0]    rc [NREQ];
  logic [31:0]   ra [NREQ];
  logic [31:0]   rw [NREQ];

  assign req_i   = {rq[1], rq[0]};
  assign cmd_i   = {rc[1], rc[0]};
  assign addr_i  = {ra[1], ra[0]};
  assign wdata_i = {rw[1], rw[0]};

  always #5 clk = ~clk;

  dbg_cmd_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .cmd_i(cmd_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o),
    .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o),
    .dbg_wdata_o(dbg_wdata_o), .dbg_rdata_i(dbg_rdata_i),
    .dbg_done_i(dbg_done_i)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  int          last;
  int          cur_w;
  int          core_cnt;
  int          core_d;
  int          done_left;
  logic [31:0] core_rd;
  logic [31:0] exp_rd;
  logic        exp_err;
  logic [7:0]  exp_cmd;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  bit          ack_due;
  bit          busy_prev;
  int          gap [NREQ];
  int          n_done [NREQ];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(int lst, logic [1:0] r);
    int c;
    for (int i = 1; i <= NREQ; i++) begin
      c = (lst + i) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic wait_grant(string tag, logic [7:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_cmd_o == 8'h00 && n < 12);
    chk(tag, 32'(dbg_cmd_o), 32'(exp));
    chk({tag, "_noack"}, 32'(ack_o), 32'd0);
  endtask

  task automatic serve(string tag, int k, logic [31:0] rd);
    dbg_done_i  = 1'b1;
    dbg_rdata_i = rd;
    @(negedge clk);
    chk({tag, "_ack"}, 32'(ack_o), 32'd1 << k);
    chk({tag, "_rdata"}, rdata_o, rd);
    chk({tag, "_cmdclr"}, 32'(dbg_cmd_o), 32'd0);
    dbg_done_i  = 1'b0;
    dbg_rdata_i = 32'h5555_5555;
    rq[k]       = 1'b0;
  endtask

  task automatic new_cmd(int k);
    rc[k] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    ra[k] = $urandom;
    rw[k] = $urandom;
    rq[k] = 1'b1;
  endtask

  task automatic finish_req(int k);
    n_done[k]++;
    if ($urandom_range(0, 1) == 1) new_cmd(k);
    else begin
      rq[k]  = 1'b0;
      gap[k] = $urandom_range(0, 3);
    end
  endtask

  task automatic rand_cycle();
    int w;
    int k;
    @(negedge clk);
    if (done_left > 0) begin
      done_left--;
      if (done_left == 0) dbg_done_i = 1'b0;
    end
    if (!dbg_done_i) dbg_rdata_i = $urandom;
    if (ack_due) begin
      chk("rnd_ack", 32'(ack_o), 32'd1 << cur_w);
      chk("rnd_rdata", rdata_o, exp_rd);
      chk("rnd_err", 32'(err_o), 32'(exp_err));
      chk("rnd_cmdclr", 32'(dbg_cmd_o), 32'd0);
      ack_due = 1'b0;
      k       = cur_w;
      cur_w   = -1;
      finish_req(k);
    end else if (busy_o && !busy_prev) begin
      w = rr_pick(last, req_i);
      chk("rnd_grant_has_req", 32'(w >= 0), 32'd1);
      if (w >= 0) begin
        last = w;
        if (rc[w] == 8'h00) begin
          chk("rnd_zero_ack", 32'(ack_o), 32'd1 << w);
          chk("rnd_zero_cmd", 32'(dbg_cmd_o), 32'd0);
          chk("rnd_zero_err", 32'(err_o), 32'd0);
          chk("rnd_zero_rdata", rdata_o, 32'd0);
          finish_req(w);
        end else begin
          exp_cmd   = rc[w];
          exp_addr  = ra[w];
          exp_wdata = rw[w];
          chk("rnd_grant_ack", 32'(ack_o), 32'd0);
          chk("rnd_addr", dbg_addr_o, exp_addr);
          chk("rnd_wdata", dbg_wdata_o, exp_wdata);
          cur_w    = w;
          core_cnt = 0;
          core_d   = ($urandom_range(0, 3) == 0) ? TMO
                                                 : $urandom_range(1, TMO + 4);
          core_rd  = $urandom;
          if ($urandom_range(0, 3) == 0) rq[w] = 1'b0;
        end
      end
    end else begin
      chk("rnd_idle_ack", 32'(ack_o), 32'd0);
    end
    if (cur_w >= 0 && !ack_due) begin
      core_cnt++;
      chk("rnd_hold", 32'(dbg_cmd_o), 32'(exp_cmd));
      if (core_cnt == core_d) begin
        dbg_done_i  = 1'b1;
        dbg_rdata_i = core_rd;
        done_left   = $urandom_range(1, 4);
        ack_due     = 1'b1;
        exp_rd      = core_rd;
        exp_err     = 1'b0;
      end else if (core_cnt == TMO) begin
        ack_due = 1'b1;
        exp_rd  = 32'd0;
        exp_err = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!rq[j] && j != cur_w) begin
        if (gap[j] == 0) new_cmd(j);
        else gap[j]--;
      end
    end
    busy_prev = busy_o;
  endtask

  initial begin
    int cnt;
    bit seen;
    rstn_i      = 1'b0;
    dbg_done_i  = 1'b0;
    dbg_rdata_i = 32'h5555_5555;
    for (int j = 0; j < NREQ; j++) begin
      rq[j] = 1'b0; rc[j] = '0; ra[j] = '0; rw[j] = '0;
      gap[j] = 0; n_done[j] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_cmd", 32'(dbg_cmd_o), 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);

    // both requesting from reset, with a lingering done
    rq[0] = 1'b1; rc[0] = 8'h01; ra[0] = 32'h10; rw[0] = 32'hA0;
    rq[1] = 1'b1; rc[1] = 8'h02; ra[1] = 32'h20; rw[1] = 32'hB0;
    rstn_i = 1'b1;
    wait_grant("t2_first", 8'h01);
    dbg_done_i  = 1'b1;
    dbg_rdata_i = 32'h0000_AAAA;
    @(negedge clk);
    chk("t4_ack", 32'(ack_o), 32'd1);
    chk("t4_rdata", rdata_o, 32'h0000_AAAA);
    rq[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_off", 32'(dbg_cmd_o), 32'd0);
      chk("t4_busy", 32'(busy_o), 32'd1);
    end
    dbg_done_i = 1'b0;
    @(negedge clk);
    chk("t4_idle_cmd", 32'(dbg_cmd_o), 32'd0);
    @(negedge clk);
    chk("t4_next_cmd", 32'(dbg_cmd_o), 32'h02);
    serve("t2_second", 1, 32'h0000_BBBB);
    rq[0] = 1'b1;
    rq[1] = 1'b1;
    wait_grant("t2_rot0", 8'h01);
    serve("t2_rot0", 0, 32'h1);
    wait_grant("t2_rot1", 8'h02);
    serve("t2_rot1", 1, 32'h2);

    // single command with exact latency
    @(negedge clk);
    rc[0] = 8'h05; ra[0] = 32'h0000_0011; rw[0] = 32'hCAFE_0001;
    rq[0] = 1'b1;
    @(negedge clk);
    chk("t1_cmd", 32'(dbg_cmd_o), 32'h05);
    chk("t1_addr", dbg_addr_o, 32'h0000_0011);
    chk("t1_wdata", dbg_wdata_o, 32'hCAFE_0001);
    chk("t1_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    dbg_done_i  = 1'b1;
    dbg_rdata_i = 32'h0000_1000;
    @(negedge clk);
    chk("t1_ack", 32'(ack_o), 32'd1);
    chk("t1_rdata", rdata_o, 32'h0000_1000);
    chk("t1_err", 32'(err_o), 32'd0);
    chk("t1_cmdclr", 32'(dbg_cmd_o), 32'd0);
    chk("t1_addrclr", dbg_addr_o, 32'd0);
    dbg_done_i  = 1'b0;
    dbg_rdata_i = 32'h5555_5555;
    rq[0] = 1'b0;
    @(negedge clk);
    chk("t1_ack_pulse", 32'(ack_o), 32'd0);
    chk("t1_rdata_pulse", rdata_o, 32'd0);
    chk("t1_idle", 32'(busy_o), 32'd0);

    // zero command completes without bus activity
    rc[0] = 8'h00;
    rq[0] = 1'b1;
    @(negedge clk);
    chk("t6_ack", 32'(ack_o), 32'd1);
    chk("t6_cmd", 32'(dbg_cmd_o), 32'd0);
    chk("t6_err", 32'(err_o), 32'd0);
    chk("t6_rdata", rdata_o, 32'd0);
    rq[0] = 1'b0;
    @(negedge clk);
    chk("t6_ack_pulse", 32'(ack_o), 32'd0);
    chk("t6_cmd_after", 32'(dbg_cmd_o), 32'd0);

    // timeout: debug unit never answers
    rc[1] = 8'h03;
    rq[1] = 1'b1;
    cnt   = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack_o != 2'b00) seen = 1'b1;
      else if (dbg_cmd_o == 8'h03) cnt++;
    end
    chk("t3_cycles", cnt, TMO);
    chk("t3_ack", 32'(ack_o), 32'd2);
    chk("t3_err", 32'(err_o), 32'd1);
    chk("t3_rdata", rdata_o, 32'd0);
    chk("t3_cmdclr", 32'(dbg_cmd_o), 32'd0);
    rq[1] = 1'b0;

    // reset mid-command restores priority to req0
    rc[0] = 8'h07;
    rq[0] = 1'b1;
    wait_grant("t5_pre", 8'h07);
    #2 rstn_i = 1'b0;
    #1;
    chk("t5_cmd", 32'(dbg_cmd_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_addr", dbg_addr_o, 32'd0);
    chk("t5_ack", 32'(ack_o), 32'd0);
    rc[1] = 8'h09;
    rq[1] = 1'b1;
    @(negedge clk);
    rstn_i = 1'b1;
    wait_grant("t5_first", 8'h07);
    serve("t5_first", 0, 32'h7);
    wait_grant("t5_second", 8'h09);
    serve("t5_second", 1, 32'h9);

    // randomized traffic
    @(negedge clk);
    rstn_i = 1'b0;
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    @(negedge clk);
    last      = NREQ - 1;
    cur_w     = -1;
    done_left = 0;
    ack_due   = 1'b0;
    busy_prev = 1'b0;
    for (int j = 0; j < NREQ; j++) gap[j] = $urandom_range(0, 2);
    rstn_i = 1'b1;
    for (int i = 0; i < 2000; i++) rand_cycle();
    chk("rnd_progress0", 32'(n_done[0] > 30), 32'd1);
    chk("rnd_progress1", 32'(n_done[1] > 30), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
